// File: rtl/uart_bus_arbiter_if.sv
// UART core register bus: 4-bit address, active-low chip select and strobes,
// 8-bit write data towards the core and 8-bit read data back from it.
interface uart_bus_arbiter_if;
    logic [3:0] AddrBus_o;
    logic       n_ChipSelect_o;
    logic       n_rd_o;
    logic       n_we_o;
    logic [7:0] DataBus_o;
    logic [7:0] DataBus_i;

    // The arbiter drives the core bus.
    modport master (
        output AddrBus_o,
        output n_ChipSelect_o,
        output n_rd_o,
        output n_we_o,
        output DataBus_o,
        input  DataBus_i
    );

    // The UART core receives the bus and returns read data.
    modport slave (
        input  AddrBus_o,
        input  n_ChipSelect_o,
        input  n_rd_o,
        input  n_we_o,
        input  DataBus_o,
        output DataBus_i
    );
endinterface

// File: rtl/uart_bus_arbiter.sv
// Two-requester round-robin arbiter for the UART core register bus.
// Each granted access runs SETUP -> STROBE -> DONE and issues exactly one
// active-low read or write strobe, so FIFO side effects fire once per access.
// Every output is registered; outputs are computed from the next state.
module uart_bus_arbiter #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_i,
    input  logic       we0_i,
    input  logic [3:0] addr0_i,
    input  logic [7:0] wdata0_i,
    output logic       ack0_o,
    output logic [7:0] rdata0_o,
    input  logic       req1_i,
    input  logic       we1_i,
    input  logic [3:0] addr1_i,
    input  logic [7:0] wdata1_i,
    output logic       ack1_o,
    output logic [7:0] rdata1_o,
    uart_bus_arbiter_if.master bus,
    output logic       busy_o,
    output logic       grant_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Phase counter reload values: count down to zero, then leave the state.
    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);

    state_t     state_r, state_s;
    logic [3:0] cnt_r, cnt_s;
    logic       grant_r, grant_s;
    logic       last_grant_r;
    logic       we_r, we_s;
    logic [3:0] addr_r, addr_s;
    logic [7:0] wdata_r, wdata_s;
    logic       n_cs_r, n_rd_r, n_we_r;
    logic       ack0_r, ack1_r;
    logic [7:0] rdata0_r, rdata1_r;
    logic       busy_r;

    // Next-state logic: arbitration and input latching in IDLE, phase timing elsewhere.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        grant_s = grant_r;
        we_s    = we_r;
        addr_s  = addr_r;
        wdata_s = wdata_r;
        case (state_r)
            ST_IDLE: begin
                if (req0_i || req1_i) begin
                    // Under contention the requester that did not go last wins.
                    if (req0_i && req1_i) begin
                        grant_s = ~last_grant_r;
                    end else begin
                        grant_s = req1_i;
                    end
                    if (grant_s) begin
                        we_s    = we1_i;
                        addr_s  = addr1_i;
                        wdata_s = wdata1_i;
                    end else begin
                        we_s    = we0_i;
                        addr_s  = addr0_i;
                        wdata_s = wdata0_i;
                    end
                    state_s = ST_SETUP;
                    cnt_s   = SETUP_LD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_STROBE;
                    cnt_s   = STROBE_LD;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_STROBE: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_DONE;
                    cnt_s   = 4'd0;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State, latched request and bus output registers; reset forces strobes and chip select high at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
            we_r         <= 1'b0;
            addr_r       <= 4'd0;
            wdata_r      <= 8'd0;
            n_cs_r       <= 1'b1;
            n_rd_r       <= 1'b1;
            n_we_r       <= 1'b1;
            ack0_r       <= 1'b0;
            ack1_r       <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            grant_r <= grant_s;
            we_r    <= we_s;
            addr_r  <= addr_s;
            wdata_r <= wdata_s;
            n_cs_r  <= !((state_s == ST_SETUP) || (state_s == ST_STROBE));
            n_rd_r  <= !((state_s == ST_STROBE) && !we_s);
            n_we_r  <= !((state_s == ST_STROBE) && we_s);
            ack0_r  <= (state_s == ST_DONE) && !grant_s;
            ack1_r  <= (state_s == ST_DONE) && grant_s;
            busy_r  <= (state_s != ST_IDLE);
            if (state_r == ST_DONE) begin
                last_grant_r <= grant_r;
            end
        end
    end

    // Read data is captured at the edge that ends the last strobe cycle and held until the next read on that port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata0_r <= 8'd0;
            rdata1_r <= 8'd0;
        end else if ((state_r == ST_STROBE) && (cnt_r == 4'd0) && !we_r) begin
            if (grant_r) begin
                rdata1_r <= bus.DataBus_i;
            end else begin
                rdata0_r <= bus.DataBus_i;
            end
        end
    end

    assign bus.AddrBus_o      = addr_r;
    assign bus.DataBus_o      = wdata_r;
    assign bus.n_ChipSelect_o = n_cs_r;
    assign bus.n_rd_o         = n_rd_r;
    assign bus.n_we_o         = n_we_r;
    assign ack0_o             = ack0_r;
    assign ack1_o             = ack1_r;
    assign rdata0_o           = rdata0_r;
    assign rdata1_o           = rdata1_r;
    assign busy_o             = busy_r;
    assign grant_o            = grant_r;

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Self-checking bench for uart_bus_arbiter: a vector table of single accesses,
// hand-written contention / reset / early-drop sequences, and a bus monitor
// that pops an expected-access scoreboard on every ack.
module tb_uart_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [3:0] addr0 = 4'd0, addr1 = 4'd0;
    logic [7:0] wdata0 = 8'd0, wdata1 = 8'd0;
    logic       ack0, ack1, busy, grant;
    logic [7:0] rdata0, rdata1;

    uart_bus_arbiter_if bus();

    uart_bus_arbiter #(.SETUP_CYC(1), .STROBE_CYC(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0_i   (req0),
        .we0_i    (we0),
        .addr0_i  (addr0),
        .wdata0_i (wdata0),
        .ack0_o   (ack0),
        .rdata0_o (rdata0),
        .req1_i   (req1),
        .we1_i    (we1),
        .addr1_i  (addr1),
        .wdata1_i (wdata1),
        .ack1_o   (ack1),
        .rdata1_o (rdata1),
        .bus      (bus),
        .busy_o   (busy),
        .grant_o  (grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       port;
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] din;
        logic [7:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic       port;
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } exp_t;

    exp_t       sb[$];
    int         test_cnt = 0;
    int         fail_cnt = 0;
    int         ack_total = 0;
    int         strobe_total = 0;
    logic [7:0] model_rdata [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        test_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus monitor: timing invariants every cycle, scoreboard pop on every ack.
    initial begin : monitor
        int         strobe_len;
        int         cs_low_len;
        int         cs_high_len;
        int         strobes_since_ack;
        logic       s_we;
        logic [3:0] s_addr;
        logic [7:0] s_wdata;
        logic       strobe_low;
        exp_t       e;
        strobe_len = 0; cs_low_len = 0; cs_high_len = 2; strobes_since_ack = 0;
        s_we = 1'b0; s_addr = 4'd0; s_wdata = 8'd0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                strobe_len = 0; cs_low_len = 0; cs_high_len = 2; strobes_since_ack = 0;
            end else begin
                strobe_low = !bus.n_rd_o || !bus.n_we_o;
                check("strobes_exclusive", {31'd0, !bus.n_rd_o && !bus.n_we_o}, 32'd0);
                check("strobe_without_cs", {31'd0, strobe_low && bus.n_ChipSelect_o}, 32'd0);
                check("busy_vs_bus", {31'd0, busy}, {31'd0, !bus.n_ChipSelect_o || ack0 || ack1});
                if (!bus.n_ChipSelect_o) begin
                    if (cs_low_len == 0) check("cs_high_gap_ge2", {31'd0, cs_high_len >= 2}, 32'd1);
                    cs_low_len++;
                    cs_high_len = 0;
                end else begin
                    if (cs_low_len != 0) check("cs_low_cycles", cs_low_len, 32'd3);
                    cs_low_len = 0;
                    cs_high_len++;
                end
                if (strobe_low) begin
                    if (strobe_len == 0) begin
                        s_we = !bus.n_we_o; s_addr = bus.AddrBus_o; s_wdata = bus.DataBus_o;
                        strobes_since_ack++;
                        strobe_total++;
                    end
                    strobe_len++;
                end else begin
                    if (strobe_len != 0) check("strobe_cycles", strobe_len, 32'd2);
                    strobe_len = 0;
                end
                if (ack0 || ack1) begin
                    ack_total++;
                    check("ack_onehot", {31'd0, ack0 && ack1}, 32'd0);
                    if (sb.size() == 0) begin
                        check("unexpected_ack", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("ack_port", {31'd0, ack1}, {31'd0, e.port});
                        check("grant_at_ack", {31'd0, grant}, {31'd0, e.port});
                        check("one_strobe_per_access", strobes_since_ack, 32'd1);
                        check("strobe_dir", {31'd0, s_we}, {31'd0, e.we});
                        check("strobe_addr", {28'd0, s_addr}, {28'd0, e.addr});
                        if (e.we) check("strobe_wdata", {24'd0, s_wdata}, {24'd0, e.wdata});
                        check("rdata_at_ack", {24'd0, e.port ? rdata1 : rdata0}, {24'd0, e.rdata});
                    end
                    strobes_since_ack = 0;
                end
            end
        end
    end

    // One access from the table: push expectation, drive request, wait for ack and check latency.
    task automatic do_access(input vec_t v);
        exp_t e;
        int   cyc;
        logic got;
        e.port = v.port; e.we = v.we; e.addr = v.addr; e.wdata = v.wdata; e.rdata = v.exp_rdata;
        sb.push_back(e);
        model_rdata[v.port] = v.exp_rdata;
        bus.DataBus_i = v.din;
        if (v.port) begin
            req0 = 1'b0; req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
        end else begin
            req1 = 1'b0; req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
        end
        cyc = 0; got = 1'b0;
        while (!got && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            got = v.port ? ack1 : ack0;
        end
        check("ack_latency", cyc, 32'd4);
        @(posedge clk); #1;
    endtask

    vec_t vecs [9];

    initial begin : main
        int   base_ack;
        int   base_str;
        int   cyc;
        exp_t e;
        // port, we, addr, wdata, din, expected rdata of that port at ack
        vecs[0] = '{1'b0, 1'b0, 4'h3, 8'h00, 8'hA5, 8'hA5};   // T1 read
        vecs[1] = '{1'b1, 1'b1, 4'h1, 8'h5C, 8'h00, 8'h00};   // T2 write, rdata1 still reset value
        vecs[2] = '{1'b1, 1'b0, 4'hF, 8'h00, 8'h3C, 8'h3C};
        vecs[3] = '{1'b0, 1'b1, 4'h0, 8'hFF, 8'h12, 8'hA5};   // write leaves rdata0
        vecs[4] = '{1'b1, 1'b1, 4'h7, 8'h81, 8'h34, 8'h3C};
        vecs[5] = '{1'b0, 1'b0, 4'h8, 8'h00, 8'h00, 8'h00};
        vecs[6] = '{1'b0, 1'b1, 4'h4, 8'h44, 8'hEE, 8'h00};   // T4 back-to-back writes
        vecs[7] = '{1'b0, 1'b1, 4'h5, 8'h55, 8'hEE, 8'h00};
        vecs[8] = '{1'b0, 1'b1, 4'h6, 8'h66, 8'hEE, 8'h00};
        model_rdata[0] = 8'h00;
        model_rdata[1] = 8'h00;
        bus.DataBus_i = 8'h00;

        // Reset values.
        #12;
        check("rst_addr", {28'd0, bus.AddrBus_o}, 32'd0);
        check("rst_dout", {24'd0, bus.DataBus_o}, 32'd0);
        check("rst_ncs", {31'd0, bus.n_ChipSelect_o}, 32'd1);
        check("rst_nrd", {31'd0, bus.n_rd_o}, 32'd1);
        check("rst_nwe", {31'd0, bus.n_we_o}, 32'd1);
        check("rst_ack0", {31'd0, ack0}, 32'd0);
        check("rst_ack1", {31'd0, ack1}, 32'd0);
        check("rst_rdata0", {24'd0, rdata0}, 32'd0);
        check("rst_rdata1", {24'd0, rdata1}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_grant", {31'd0, grant}, 32'd0);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;

        // T1, T2, T4 and assorted single accesses.
        for (int i = 0; i < 9; i++) do_access(vecs[i]);
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // T5: reset during STROBE of a port-0 write.
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'h7; wdata0 = 8'h77;
        cyc = 0;
        while (bus.n_we_o && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("t5_strobe_reached", {31'd0, bus.n_we_o}, 32'd0);
        base_ack = ack_total;
        #2 rst = 1'b0;
        #1;
        check("t5_nwe_high", {31'd0, bus.n_we_o}, 32'd1);
        check("t5_nrd_high", {31'd0, bus.n_rd_o}, 32'd1);
        check("t5_ncs_high", {31'd0, bus.n_ChipSelect_o}, 32'd1);
        check("t5_busy_low", {31'd0, busy}, 32'd0);
        check("t5_no_ack0", {31'd0, ack0}, 32'd0);
        req0 = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        model_rdata[0] = 8'h00;
        model_rdata[1] = 8'h00;
        check("t5_rdata0_cleared", {24'd0, rdata0}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t5_no_ack_after_reset", ack_total, base_ack);

        // T3: contention right after reset; requester 0 must win first.
        base_ack = ack_total;
        base_str = strobe_total;
        bus.DataBus_i = 8'h96;
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'h2; wdata0 = 8'h00;
        req1 = 1'b1; we1 = 1'b1; addr1 = 4'h9; wdata1 = 8'h11;
        for (int i = 0; i < 4; i++) begin
            e.port = (i % 2 == 1);
            if (e.port) begin
                e.we = 1'b1; e.addr = 4'h9; e.wdata = 8'h11; e.rdata = model_rdata[1];
            end else begin
                e.we = 1'b0; e.addr = 4'h2; e.wdata = 8'h00;
                model_rdata[0] = 8'h96; e.rdata = 8'h96;
            end
            sb.push_back(e);
        end
        cyc = 0;
        while (ack_total < base_ack + 4 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        req0 = 1'b0; req1 = 1'b0;
        check("t3_ack_count", ack_total - base_ack, 32'd4);
        check("t3_strobe_count", strobe_total - base_str, 32'd4);
        repeat (2) @(posedge clk);
        #1;

        // T6: requester 1 drops its read request during SETUP.
        base_ack = ack_total;
        base_str = strobe_total;
        bus.DataBus_i = 8'h5A;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'hA; wdata1 = 8'h00;
        e.port = 1'b1; e.we = 1'b0; e.addr = 4'hA; e.wdata = 8'h00; e.rdata = 8'h5A;
        sb.push_back(e);
        model_rdata[1] = 8'h5A;
        @(posedge clk); #1;
        req1 = 1'b0; addr1 = 4'h0; we1 = 1'b1;
        cyc = 0;
        while (ack_total < base_ack + 1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("t6_ack_count", ack_total - base_ack, 32'd1);
        check("t6_strobe_count", strobe_total - base_str, 32'd1);
        check("t6_rdata1", {24'd0, rdata1}, {24'd0, model_rdata[1]});
        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 32'd0);
        check("no_extra_ack", ack_total - base_ack, 32'd1);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
